// File: rtl/step_countdown_timer_pkg.sv
// Shared types and helpers for the step countdown timer.
package step_countdown_timer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } timer_state_e;

  // Size of one decrement step for a given shift.
  function automatic int unsigned step_of(input int unsigned shift);
    return 32'd1 << shift;
  endfunction

endpackage

// File: rtl/step_countdown_timer_decrementer.sv
// Combinational decrement by 2**STEP_SHIFT; bits below STEP_SHIFT pass through untouched.
module step_countdown_timer_decrementer #(
  parameter int WIDTH      = 8,
  parameter int STEP_SHIFT = 0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic borrow;

  // Ripple borrow: a bit flips when every upper-field bit below it is zero.
  always_comb begin
    data_o = data_i;
    borrow = 1'b1;
    for (int i = STEP_SHIFT; i < WIDTH; i++) begin
      data_o[i] = data_i[i] ^ borrow;
      borrow    = borrow & ~data_i[i];
    end
  end

endmodule

// File: rtl/step_countdown_timer.sv
// Loadable countdown timer stepping down by 2**STEP_SHIFT per enabled cycle.
module step_countdown_timer
  import step_countdown_timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STEP_SHIFT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned Step = step_of(STEP_SHIFT);

  if (WIDTH < 2 || STEP_SHIFT < 0 || STEP_SHIFT >= WIDTH) begin : g_param_check
    $error("step_countdown_timer: need WIDTH >= 2 and 0 <= STEP_SHIFT < WIDTH");
  end

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] dec_count;

  step_countdown_timer_decrementer #(
    .WIDTH      (WIDTH),
    .STEP_SHIFT (STEP_SHIFT)
  ) u_dec (
    .data_i (count_q),
    .data_o (dec_count)
  );

  // Next-state: load in idle, decrement/abort in run, done pulse on reaching hi == 0.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_valid_i) begin
          count_d = load_value_i;
          if (load_value_i[WIDTH-1:STEP_SHIFT] != '0) begin
            state_d = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (enable_i) begin
          count_d = dec_count;
          if (dec_count[WIDTH-1:STEP_SHIFT] == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun);
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign load_ready_o = (state_q == StIdle);
  assign count_o      = count_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  // RUN always leaves at hi == 0, so the decrementer never wraps while in use.
  a_no_wrap: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StRun && enable_i && !abort_i) |-> (count_q[WIDTH-1:STEP_SHIFT] != '0));

  a_dec_step: assert property (@(posedge clk_i) disable iff (rst_i)
    dec_count == count_q - WIDTH'(Step));

endmodule

// File: tb/tb_step_countdown_timer.sv
// Scoreboard bench: each scenario queues stimulus and expected outputs per cycle.
module tb_step_countdown_timer;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  typedef struct packed {
    logic       lv;
    logic [7:0] val;
    logic       en;
    logic       ab;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, load_valid_s, enable, abort;
  logic [7:0] load_value;
  logic [3:0] load_value_s;
  logic       load_ready, busy, done;
  logic [7:0] count;
  logic       load_ready_s, busy_s, done_s;
  logic [3:0] count_s;

  int tests_run    = 0;
  int tests_failed = 0;

  stim_t stim_q[$];
  obs_t  exp_q[$];

  always #5 clk = ~clk;

  step_countdown_timer #(.WIDTH(8), .STEP_SHIFT(2)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_value_i (load_value),
    .enable_i     (enable),
    .abort_i      (abort),
    .count_o      (count),
    .busy_o       (busy),
    .done_o       (done)
  );

  step_countdown_timer #(.WIDTH(4), .STEP_SHIFT(0)) u_dut_small (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_valid_i (load_valid_s),
    .load_ready_o (load_ready_s),
    .load_value_i (load_value_s),
    .enable_i     (enable),
    .abort_i      (abort),
    .count_o      (count_s),
    .busy_o       (busy_s),
    .done_o       (done_s)
  );

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    load_valid = 0; load_valid_s = 0; enable = 0; abort = 0;
    load_value = '0; load_value_s = '0;
    #12;
    exp_q.push_back('{count: 8'h00, busy: 0, done: 0, ready: 1});
    o = '{count: count, busy: busy, done: done, ready: load_ready};
    tests_run++;
    if (o !== exp_q.pop_front()) begin
      $display("FAIL reset: got %h want %h", o, obs_t'{8'h00, 1'b0, 1'b0, 1'b1});
      tests_failed++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    stim_t s; obs_t o, e;
    stim_q.push_back('{lv: 1, val: 8'h0D, en: 1, ab: 0}); exp_q.push_back('{8'h0D, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h09, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h05, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h01, 1'b0, 1'b1, 1'b1});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h01, 1'b0, 1'b0, 1'b1});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid = s.lv; load_value = s.val; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: count, busy: busy, done: done, ready: load_ready};
      tests_run++;
      if (o !== e) begin
        $display("FAIL basic: got %h want %h", o, e);
        tests_failed++;
      end
    end
    enable = 0;
  endtask

  task automatic test_zero_length();
    stim_t s; obs_t o, e;
    stim_q.push_back('{lv: 1, val: 8'h03, en: 0, ab: 0}); exp_q.push_back('{8'h03, 1'b0, 1'b1, 1'b1});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 1}); exp_q.push_back('{8'h03, 1'b0, 1'b0, 1'b1});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid = s.lv; load_value = s.val; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: count, busy: busy, done: done, ready: load_ready};
      tests_run++;
      if (o !== e) begin
        $display("FAIL zero_length: got %h want %h", o, e);
        tests_failed++;
      end
    end
    enable = 0; abort = 0;
  endtask

  task automatic test_stall();
    stim_t s; obs_t o, e;
    stim_q.push_back('{lv: 1, val: 8'hFF, en: 1, ab: 0}); exp_q.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'hFB, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 0, ab: 0}); exp_q.push_back('{8'hFB, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 0, ab: 0}); exp_q.push_back('{8'hFB, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'hF7, 1'b1, 1'b0, 1'b0});
    // 61 more enabled edges bring hi from 61 to 0 (63 enabled edges total).
    for (int k = 1; k <= 61; k++) begin
      logic [5:0] hi;
      hi = 6'(61 - k);
      stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0});
      exp_q.push_back('{{hi, 2'b11}, (hi != 0), (hi == 0), (hi == 0)});
    end
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h03, 1'b0, 1'b0, 1'b1});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid = s.lv; load_value = s.val; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: count, busy: busy, done: done, ready: load_ready};
      tests_run++;
      if (o !== e) begin
        $display("FAIL stall: got %h want %h", o, e);
        tests_failed++;
      end
    end
    enable = 0;
  endtask

  task automatic test_abort();
    stim_t s; obs_t o, e;
    stim_q.push_back('{lv: 1, val: 8'h20, en: 1, ab: 0}); exp_q.push_back('{8'h20, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h1C, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h18, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 1}); exp_q.push_back('{8'h18, 1'b0, 1'b0, 1'b1});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h18, 1'b0, 1'b0, 1'b1});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid = s.lv; load_value = s.val; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: count, busy: busy, done: done, ready: load_ready};
      tests_run++;
      if (o !== e) begin
        $display("FAIL abort: got %h want %h", o, e);
        tests_failed++;
      end
    end
    enable = 0; abort = 0;
  endtask

  task automatic test_back_to_back();
    stim_t s; obs_t o, e;
    stim_q.push_back('{lv: 1, val: 8'h09, en: 1, ab: 0}); exp_q.push_back('{8'h09, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 1, val: 8'h06, en: 1, ab: 0}); exp_q.push_back('{8'h05, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 1, val: 8'h06, en: 1, ab: 0}); exp_q.push_back('{8'h01, 1'b0, 1'b1, 1'b1});
    stim_q.push_back('{lv: 1, val: 8'h06, en: 1, ab: 0}); exp_q.push_back('{8'h06, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h02, 1'b0, 1'b1, 1'b1});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h02, 1'b0, 1'b0, 1'b1});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid = s.lv; load_value = s.val; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: count, busy: busy, done: done, ready: load_ready};
      tests_run++;
      if (o !== e) begin
        $display("FAIL back_to_back: got %h want %h", o, e);
        tests_failed++;
      end
    end
    enable = 0;
  endtask

  task automatic test_async_reset();
    stim_t s; obs_t o, e;
    stim_q.push_back('{lv: 1, val: 8'h40, en: 1, ab: 0}); exp_q.push_back('{8'h40, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid = s.lv; load_value = s.val; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: count, busy: busy, done: done, ready: load_ready};
      tests_run++;
      if (o !== e) begin
        $display("FAIL async_reset pre: got %h want %h", o, e);
        tests_failed++;
      end
    end
    // Mid-cycle assertion: outputs must clear without waiting for an edge.
    #2 rst = 1'b1;
    #1;
    exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
    e = exp_q.pop_front();
    o = '{count: count, busy: busy, done: done, ready: load_ready};
    tests_run++;
    if (o !== e) begin
      $display("FAIL async_reset immediate: got %h want %h", o, e);
      tests_failed++;
    end
    @(posedge clk); #3 rst = 1'b0;
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
    stim_q.push_back('{lv: 1, val: 8'h05, en: 1, ab: 0}); exp_q.push_back('{8'h05, 1'b1, 1'b0, 1'b0});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h01, 1'b0, 1'b1, 1'b1});
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h01, 1'b0, 1'b0, 1'b1});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid = s.lv; load_value = s.val; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: count, busy: busy, done: done, ready: load_ready};
      tests_run++;
      if (o !== e) begin
        $display("FAIL async_reset post: got %h want %h", o, e);
        tests_failed++;
      end
    end
    enable = 0;
  endtask

  task automatic test_small_width();
    stim_t s; obs_t o, e;
    stim_q.push_back('{lv: 1, val: 8'h0F, en: 1, ab: 0}); exp_q.push_back('{8'h0F, 1'b1, 1'b0, 1'b0});
    for (int k = 1; k <= 15; k++) begin
      stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0});
      exp_q.push_back('{8'(15 - k), (k != 15), (k == 15), (k == 15)});
    end
    stim_q.push_back('{lv: 0, val: 8'h00, en: 1, ab: 0}); exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      load_valid_s = s.lv; load_value_s = s.val[3:0]; enable = s.en; abort = s.ab;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = '{count: {4'h0, count_s}, busy: busy_s, done: done_s, ready: load_ready_s};
      tests_run++;
      if (o !== e) begin
        $display("FAIL small_width: got %h want %h", o, e);
        tests_failed++;
      end
    end
    enable = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_small_width();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
